// File: rtl/stat_disp_pkg.sv
// Shared types and constants for the statistics display:
// FSM encoding, counter select codes, 7-segment glyphs.
package stat_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SUM  = 2'd0;
    localparam logic [1:0] SEL_NCO  = 2'd1;
    localparam logic [1:0] SEL_CO   = 2'd2;
    localparam logic [1:0] SEL_COSU = 2'd3;

    localparam int BCD_W = 40;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits,
// one bit per cycle, 32 cycles after start.
module bin2bcd_seq
    import stat_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [31:0]      r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [4:0]       r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    for (genvar g = 0; g < BCD_W / 4; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                 r_bcd[4*g +: 4] + 4'd3 :
                                 r_bcd[4*g +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[31]};
            r_bin <= {r_bin[30:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
                r_active <= 1'b0;
        end
    end

    // high during the cycle whose edge performs the 32nd shift
    assign done = r_active && (r_cnt == 5'd31);
    assign bcd  = r_bcd;

endmodule

// File: rtl/stat_display.sv
// Statistics counter viewer: selects a counter, converts to
// decimal or hex, and scans it onto an 8-digit 7-seg display.
module stat_display
    import stat_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sum,
    input  logic [31:0] nco,
    input  logic [31:0] co,
    input  logic [31:0] cosu,
    input  logic [1:0]  sel,
    input  logic        dec_mode,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy,
    output logic        ovf
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t           r_state, w_next;
    logic [1:0]       r_sel_q;
    logic             r_dec_q;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_pending;
    logic [31:0]      r_val;
    logic             r_mode;
    logic [31:0]      r_disp;
    logic             r_disp_dec;
    logic             r_ovf;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic             w_ref_hit, w_trig;
    logic             w_load, w_write;
    logic [31:0]      w_sel_val;
    logic [BCD_W-1:0] w_bcd;
    logic             w_done;
    logic [3:0]       w_nib;
    logic             w_blank;

    always_comb begin
        unique case (sel)
            SEL_SUM: w_sel_val = sum;
            SEL_NCO: w_sel_val = nco;
            SEL_CO:  w_sel_val = co;
            default: w_sel_val = cosu;
        endcase
    end

    // unreset so the first cycle after reset sees no spurious change
    always_ff @(posedge clk) begin
        r_sel_q <= sel;
        r_dec_q <= dec_mode;
    end

    assign w_ref_hit = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));
    assign w_trig    = w_ref_hit || (sel != r_sel_q) ||
                       (dec_mode != r_dec_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_cnt <= '0;
            r_pending <= 1'b1;
        end else begin
            r_ref_cnt <= w_ref_hit ? '0 : r_ref_cnt + 1'b1;
            if (w_trig)
                r_pending <= 1'b1;
            else if (r_state == ST_IDLE)
                r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (r_pending) w_next = ST_LOAD;
            ST_LOAD:  w_next = dec_mode ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (w_done) w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load  = (r_state == ST_LOAD);
        w_write = (r_state == ST_DONE);
        busy    = (r_state != ST_IDLE);
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_load && dec_mode),
        .bin   (w_sel_val),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val      <= '0;
            r_mode     <= 1'b0;
            r_disp     <= '0;
            r_disp_dec <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load) begin
                r_val  <= w_sel_val;
                r_mode <= dec_mode;
            end
            if (w_write) begin
                r_disp     <= r_mode ? w_bcd[31:0] : r_val;
                r_ovf      <= r_mode && (w_bcd[39:32] != 8'd0);
                r_disp_dec <= r_mode;
            end
        end
    end

    assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    assign w_blank = r_disp_dec && (r_idx != 3'd0) &&
                     ((r_disp >> {r_idx, 2'b00}) == 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= 8'hFF;
            r_seg      <= 8'hFF;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= {1'b1, w_blank ? GLYPH_BLANK : glyph(w_nib)};
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_stat_display.sv
// Directed bench for stat_display: reset, scan, decimal, hex,
// overflow, retrigger while busy and reset mid-conversion.
module tb_stat_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sum, nco, co, cosu;
    logic [1:0]  sel;
    logic        dec_mode;
    logic [7:0]  an, seg;
    logic        busy, ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] cap [8];
    logic [7:0] exp_seg [8];

    always #5 clk = ~clk;

    stat_display #(
        .SCAN_DIV    (4),
        .REFRESH_DIV (1000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sum      (sum),
        .nco      (nco),
        .co       (co),
        .cosu     (cosu),
        .sel      (sel),
        .dec_mode (dec_mode),
        .an       (an),
        .seg      (seg),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic wait_conv(output int cyc);
        int t;
        t = 0;
        cyc = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!busy) begin
            n_err++;
            $display("FAIL busy_rise: busy=%0b after %0d cycles, required 1", busy, t);
        end
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL busy_fall: busy=%0b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic grab();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) cap[i] = 8'h00;
        repeat (2) @(negedge clk);
        repeat (48) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                m = ~(8'b1 << i);
                if (an === m) cap[i] = seg;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b0;
        sum = 32'd0; nco = 32'd0; co = 32'd0; cosu = 32'd0;
        sel = 2'd0; dec_mode = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({an, seg, busy, ovf} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_out: an=%h seg=%h busy=%b ovf=%b, required FF FF 0 0", an, seg, busy, ovf);
        end
        rst = 1'b1;
        wait_conv(c);
        n_cmp++;
        if (c !== 34) begin
            n_err++;
            $display("FAIL reset_latency: busy %0d cycles, required 34", c);
        end
        grab();
        exp_seg[0] = 8'hC0;
        for (int i = 1; i < 8; i++) exp_seg[i] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL reset_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
    endtask

    task automatic test_scan();
        int c, t;
        logic [7:0] step [3];
        step[0] = 8'hFD; step[1] = 8'hFB; step[2] = 8'hF7;
        co = 32'd1234;
        sel = 2'd2;
        wait_conv(c);
        n_cmp++;
        if (c !== 34) begin
            n_err++;
            $display("FAIL scan_latency: busy %0d cycles, required 34", c);
        end
        t = 0;
        while (an === 8'hFE && t < 64) begin @(negedge clk); t++; end
        while (an !== 8'hFE && t < 64) begin @(negedge clk); t++; end
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (an !== step[k]) begin
                n_err++;
                $display("FAIL scan_an%0d: an=%h, required %h", k + 1, an, step[k]);
            end
        end
        grab();
        exp_seg[0] = 8'h99; exp_seg[1] = 8'hB0;
        exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
        for (int i = 4; i < 8; i++) exp_seg[i] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL scan_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_ovf();
        int c;
        sum = 32'hFFFF_FFFF;
        sel = 2'd0;
        wait_conv(c);
        grab();
        exp_seg[0] = 8'h92; exp_seg[1] = 8'h90;
        exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF8;
        exp_seg[4] = 8'h82; exp_seg[5] = 8'h90;
        exp_seg[6] = 8'h99; exp_seg[7] = 8'h90;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL ovf_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: ovf=%b, required 1", ovf);
        end
    endtask

    task automatic test_hex();
        int c;
        cosu = 32'hDEAD_BEEF;
        sel = 2'd3;
        dec_mode = 1'b0;
        wait_conv(c);
        n_cmp++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL hex_latency: busy %0d cycles, required 2", c);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL hex_ovf: ovf=%b, required 0", ovf);
        end
        grab();
        exp_seg[0] = 8'h8E; exp_seg[1] = 8'h86;
        exp_seg[2] = 8'h86; exp_seg[3] = 8'h83;
        exp_seg[4] = 8'hA1; exp_seg[5] = 8'h88;
        exp_seg[6] = 8'h86; exp_seg[7] = 8'hA1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL hex_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int extra;
        sum = 32'd111;
        nco = 32'd222222;
        sel = 2'd0;
        dec_mode = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_midshift: busy=%b, required 1", busy);
        end
        sel = 2'd1;
        wait_conv(c);
        wait_conv(c);
        n_cmp++;
        if (c !== 34) begin
            n_err++;
            $display("FAIL b2b_second: busy %0d cycles, required 34", c);
        end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL b2b_third: busy %0d extra cycles, required 0", extra);
        end
        nco = 32'd7;
        grab();
        for (int i = 0; i < 6; i++) exp_seg[i] = 8'hA4;
        exp_seg[6] = 8'hFF; exp_seg[7] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL b2b_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int c;
        sel = 2'd2;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({an, seg, busy, ovf} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_async: an=%h seg=%h busy=%b ovf=%b, required FF FF 0 0", an, seg, busy, ovf);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_conv(c);
        n_cmp++;
        if (c !== 34) begin
            n_err++;
            $display("FAIL rst_restart: busy %0d cycles, required 34", c);
        end
        grab();
        exp_seg[0] = 8'h99; exp_seg[1] = 8'hB0;
        exp_seg[2] = 8'hA4; exp_seg[3] = 8'hF9;
        for (int i = 4; i < 8; i++) exp_seg[i] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== exp_seg[i]) begin
                n_err++;
                $display("FAIL rst_digit%0d: seg=%h, required %h", i, cap[i], exp_seg[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_ovf();
        test_hex();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stat_display.md
Name: stat_display

Overview:
- Downstream consumer of the statistics counters (total cycles, unconditional jumps, conditional branches, taken branches) on the single-cycle MIPS board build.
- Selects one 32-bit counter, converts it to decimal with a sequential double-dabble, or passes it through as hex.
- Drives an 8-digit multiplexed 7-segment display, active-low.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays enabled.
- REFRESH_DIV, 5000000: clk cycles between periodic re-conversions.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- sum  in  32  total cycle count
- nco  in  32  unconditional jump count
- co  in  32  conditional branch count
- cosu  in  32  taken conditional branch count
- sel  in  2  counter select: 0=sum, 1=nco, 2=co, 3=cosu
- dec_mode  in  1  1=decimal, 0=hex
- an  out  8  digit enables, active-low; an[0] is the rightmost digit
- seg  out  8  seg[6:0]={g,f,e,d,c,b,a}, active-low; seg[7]=dp, always 1
- busy  out  1  conversion in progress
- ovf  out  1  decimal value exceeds 99,999,999

Behaviour:
- Reset (rst=0, asynchronous):
  - an=8'hFF, seg=8'hFF, busy=0, ovf=0.
  - Display register cleared to 0, FSM in IDLE, scan and refresh counters cleared, pending=1.
- Triggers:
  - refresh counter reaching REFRESH_DIV-1 (counter then wraps to 0);
  - any change of sel or dec_mode versus its value registered in the previous cycle.
  - A trigger sets pending.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if pending, clear pending and go to LOAD.
  - LOAD: latch the selected counter into a 32-bit shift register and clear the 40-bit BCD register. Latch dec_mode. Next state is SHIFT if decimal, else DONE.
  - SHIFT: exactly 32 cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After the 32nd cycle, go to DONE.
  - DONE: write the display register, then go to IDLE.
    - Decimal: display register = BCD[31:0]; ovf = (BCD[39:32] != 0).
    - Hex: display register = latched value; ovf=0.
- busy = (state != IDLE).
- Latency: pending seen in IDLE at edge k gives a display register write at edge k+34 (decimal) or k+2 (hex).
- A trigger while busy only sets pending. The in-flight conversion completes unchanged, and exactly one further conversion follows.
- The display register changes only in DONE, so the display never shows partial results.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, digit index 0..7 increments, wrapping 7→0.
  - an = ~(8'b1 << idx), registered.
  - seg = glyph(display nibble[idx]), registered.
- Glyphs ({g..a}, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
- Leading-zero blanking in decimal mode only: digit i>0 is blank when nibbles i..7 are all zero; digit 0 always shown. Hex mode shows all 8 digits.
- Counter inputs are sampled only in LOAD; changes at other times are ignored until the next conversion.
- Reset mid-SHIFT aborts the conversion immediately, with all reset values applied. After release, a conversion starts from pending=1 (LOAD on the first edge after release).

Decomposition:
- Package stat_disp_pkg holds:
  - FSM state encoding;
  - SEL_SUM/SEL_NCO/SEL_CO/SEL_COSU codes;
  - the 17 glyph constants;
  - BCD width constant (40).
- Sub-module bin2bcd_seq implements the LOAD/SHIFT datapath.
  - Ports: clk, rst, start, bin[31:0], bcd[39:0], done.
  - The top keeps the trigger/pending logic, the hex bypass and the scan logic.

Test Plan:
- Reset held, then released with sum=0, sel=0, dec_mode=1 → an=FF and seg=FF during reset. After release, busy high for 34 cycles, then display shows "0" on digit 0 with digits 1-7 blank, ovf=0.
- co=1234, sel=2, dec_mode=1, SCAN_DIV=4 → an steps FE, FD, FB, F7, … every 4 cycles. seg per digit = 4:0011001, 3:0110000, 2:0100100, 1:1111001, digits 4-7 FF.
- sum=32'hFFFFFFFF, dec_mode=1 → digits read 94967295, ovf=1.
- cosu=32'hDEADBEEF, sel=3, dec_mode=0 → register written 2 cycles after LOAD. Digit 0 seg=8'b10001110, digit 7 seg=8'b10100001.
- sel changed 0→1 mid-SHIFT → current conversion finishes, a second LOAD follows immediately, and the final display equals nco.
- rst asserted during SHIFT → outputs FF and busy=0 asynchronously. After release, a fresh conversion completes with the correct value.
